// File: rtl/serial_parity_pkg.sv
// Shared types for the serial parity receiver.
//   rx_state_t  : receiver FSM states
//   bit_cnt_w() : bit-counter width for a given data width
//   BIT_CNT_W   : bit-counter width for the default 8-bit data path
package serial_parity_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      DONE,
      PERR,
      WAIT
   } rx_state_t;

   localparam int DATA_W_DEF = 8;
   localparam int BIT_CNT_W  = $clog2(DATA_W_DEF + 1);

   // Width needed to count 0..data_w; used by modules overriding DATA_W.
   function automatic int bit_cnt_w(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/parity_accum.sv
// Running XOR accumulator: sequential counterpart of an XOR-reduction
// parity generator.
//   clk     : clock
//   aresetn : asynchronous reset, active low
//   clr     : synchronous clear (wins over en)
//   en      : fold d into the accumulator this cycle
//   d       : bit to accumulate
//   acc     : current XOR of all bits since the last clear
module parity_accum (
   input  logic clk,
   input  logic aresetn,
   input  logic clr,
   input  logic en,
   input  logic d,
   output logic acc
);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)  acc <= 1'b0;
      else if (clr)  acc <= 1'b0;
      else if (en)   acc <= acc ^ d;
   end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial parity receiver: start(0), DATA_W data bits LSB first, parity,
// stop(1), one bit per clock. Reports good bytes, parity and framing
// errors, and keeps a saturating error count.
//   clk        : clock, rising edge
//   aresetn    : asynchronous reset, active low
//   in         : serial line, idle high
//   out_byte   : last correctly received byte
//   done       : one-cycle pulse, good frame
//   parity_err : one-cycle pulse, stop ok but parity mismatch
//   frame_err  : one-cycle pulse, stop bit sampled low
//   err_count  : saturating count of parity_err + frame_err
// DATA_W must be at least 2.
module serial_parity_rx
   import serial_parity_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PARITY_ODD = 1,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              in,
   output logic [DATA_W-1:0] out_byte,
   output logic              done,
   output logic              parity_err,
   output logic              frame_err,
   output logic [CNT_W-1:0]  err_count
);

   localparam int   BCW     = bit_cnt_w(DATA_W);
   localparam logic PAR_REF = 1'(PARITY_ODD);

   rx_state_t         state, nxt;
   logic [BCW-1:0]    bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              acc;
   logic              start;
   logic              wait_first;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:   if (!in) nxt = DATA;
         DATA:   if (bit_cnt == BCW'(DATA_W - 1)) nxt = PARITY;
         PARITY: nxt = STOP;
         STOP:   if (!in)                nxt = WAIT;
                 else if (acc == PAR_REF) nxt = DONE;
                 else                     nxt = PERR;
         // DONE/PERR double as an IDLE sample so frames can run back-to-back
         DONE,
         PERR:   nxt = in ? IDLE : DATA;
         WAIT:   if (in) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // A start bit is any transition into DATA from outside DATA.
   assign start = (nxt == DATA) && (state != DATA);

   // ---------------- datapath ----------------
   parity_accum u_acc (
      .clk     (clk),
      .aresetn (aresetn),
      .clr     (start),
      .en      ((state == DATA) || (state == PARITY)),
      .d       (in),
      .acc     (acc)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         bit_cnt    <= '0;
         shreg      <= '0;
         out_byte   <= '0;
         err_count  <= '0;
         wait_first <= 1'b0;
      end else begin
         if (start)               bit_cnt <= '0;
         else if (state == DATA)  bit_cnt <= bit_cnt + BCW'(1);

         // LSB arrives first, so shift in from the top.
         if (state == DATA) shreg <= {in, shreg[DATA_W-1:1]};

         if (state == STOP && nxt == DONE) out_byte <= shreg;

         // Count on entry to PERR/WAIT so the count already reflects the
         // error during its pulse cycle.
         if (state == STOP && nxt != DONE && err_count != '1)
            err_count <= err_count + CNT_W'(1);

         wait_first <= (state == STOP) && !in;
      end
   end

   // ---------------- Moore outputs ----------------
   assign done       = (state == DONE);
   assign parity_err = (state == PERR);
   assign frame_err  = (state == WAIT) && wait_first;

endmodule
